// File: rtl/alu_nbit_seq.sv
// Sequential N-bit ALU: single-cycle logic/add/compare ops, one-bit-per-cycle shifts
// and a shift-add multiplier behind a valid/ready command/result handshake.
module alu_nbit_seq #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             binvert,
    input  logic             carry_in,
    input  logic [2:0]       operation,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero,
    output logic             busy
);

    // Handshakes: a command is taken on a rising edge where in_valid && in_ready; a result
    // is consumed on a rising edge where out_valid && out_ready. in_ready is high only in IDLE.
    localparam int CW = SHW + 1;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} stateType;

    stateType         state;
    logic [2:0]       opReg;
    logic [WIDTH-1:0] aReg;
    logic [WIDTH-1:0] accReg;
    logic [WIDTH-1:0] loReg;
    logic [CW-1:0]    cnt;

    logic [WIDTH-1:0] mb;
    logic [WIDTH:0]   addSum;
    logic [WIDTH-1:0] sltSum;
    logic             sltOvf;
    logic [WIDTH-1:0] quickRes;
    logic             quickCo;
    logic             quickOvf;
    logic [WIDTH-1:0] shlVal;
    logic [WIDTH-1:0] srlVal;
    logic [WIDTH:0]   mulSum;
    logic [WIDTH-1:0] mulHi;
    logic [WIDTH-1:0] mulLo;
    logic [SHW-1:0]   shAmt;
    logic             lastStep;

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);
    assign shAmt    = b[SHW-1:0];
    assign lastStep = (cnt <= CW'(1));

    // Single-cycle ops resolve straight from the command inputs at accept.
    always_comb begin
        mb       = binvert ? ~b : b;
        addSum   = {1'b0, a} + {1'b0, mb} + {{WIDTH{1'b0}}, carry_in};
        sltSum   = a + ~b + {{(WIDTH-1){1'b0}}, 1'b1};
        sltOvf   = (a[WIDTH-1] != b[WIDTH-1]) && (sltSum[WIDTH-1] != a[WIDTH-1]);
        quickRes = '0;
        quickCo  = 1'b0;
        quickOvf = 1'b0;
        case (operation)
            3'b000: quickRes = a & mb;
            3'b001: quickRes = {{(WIDTH-1){1'b0}}, sltSum[WIDTH-1] ^ sltOvf};
            3'b010: quickRes = a | mb;
            3'b011: quickRes = a ^ mb;
            3'b100: begin
                quickRes = addSum[WIDTH-1:0];
                quickCo  = addSum[WIDTH];
                quickOvf = (a[WIDTH-1] == mb[WIDTH-1]) && (addSum[WIDTH-1] != a[WIDTH-1]);
            end
            default: quickRes = '0;
        endcase
    end

    // One iteration of the multi-cycle ops; accReg holds the shift value or the product high half.
    always_comb begin
        shlVal = {accReg[WIDTH-2:0], 1'b0};
        srlVal = {1'b0, accReg[WIDTH-1:1]};
        mulSum = {1'b0, accReg} + (loReg[0] ? {1'b0, aReg} : {(WIDTH+1){1'b0}});
        mulHi  = mulSum[WIDTH:1];
        mulLo  = {mulSum[0], loReg[WIDTH-1:1]};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            opReg     <= '0;
            aReg      <= '0;
            accReg    <= '0;
            loReg     <= '0;
            cnt       <= '0;
            result    <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        opReg <= operation;
                        aReg  <= a;
                        loReg <= b;
                        case (operation)
                            3'b101, 3'b110: begin
                                accReg <= a;
                                if (shAmt == '0) begin
                                    result    <= a;
                                    carry_out <= 1'b0;
                                    overflow  <= 1'b0;
                                    zero      <= (a == '0);
                                    out_valid <= 1'b1;
                                    state     <= DONE;
                                end else begin
                                    cnt   <= {1'b0, shAmt};
                                    state <= EXEC;
                                end
                            end
                            3'b111: begin
                                accReg <= '0;
                                cnt    <= CW'(WIDTH);
                                state  <= EXEC;
                            end
                            default: begin
                                result    <= quickRes;
                                carry_out <= quickCo;
                                overflow  <= quickOvf;
                                zero      <= (quickRes == '0);
                                out_valid <= 1'b1;
                                state     <= DONE;
                            end
                        endcase
                    end
                end
                EXEC: begin
                    if (cnt != '0) cnt <= cnt - CW'(1);
                    case (opReg)
                        3'b101: begin
                            accReg <= shlVal;
                            if (lastStep) begin
                                result    <= shlVal;
                                carry_out <= accReg[WIDTH-1];
                                overflow  <= 1'b0;
                                zero      <= (shlVal == '0);
                            end
                        end
                        3'b110: begin
                            accReg <= srlVal;
                            if (lastStep) begin
                                result    <= srlVal;
                                carry_out <= accReg[0];
                                overflow  <= 1'b0;
                                zero      <= (srlVal == '0);
                            end
                        end
                        default: begin
                            accReg <= mulHi;
                            loReg  <= mulLo;
                            if (lastStep) begin
                                result    <= mulLo;
                                carry_out <= (mulHi != '0);
                                overflow  <= (mulHi != '0);
                                zero      <= (mulLo == '0);
                            end
                        end
                    endcase
                    if (lastStep) begin
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_nbit_seq.sv
// Bench for alu_nbit_seq: directed cases plus random commands checked against an
// arithmetic reference model, with latency, hold-while-stalled and reset-abort checks.
module tb_alu_nbit_seq;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         binvert = 1'b0;
    logic         carry_in = 1'b0;
    logic [2:0]   operation = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] result;
    logic         carry_out;
    logic         overflow;
    logic         zero;
    logic         busy;

    int nCompared = 0;
    int nMismatch = 0;
    logic [W-1:0] expQ[$];

    alu_nbit_seq #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .binvert(binvert), .carry_in(carry_in), .operation(operation),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .carry_out(carry_out), .overflow(overflow), .zero(zero), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        nCompared++;
        assert (obs === expv) else begin
            nMismatch++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Reference model: signed/unsigned arithmetic on whole integers.
    task automatic refModel(input logic [2:0] op, input logic [W-1:0] ra, input logic [W-1:0] rb,
                            input logic binv, input logic cin, output logic [W-1:0] res,
                            output logic co, output logic ovf, output int lat);
        logic [W-1:0] mb;
        int           n;
        longint       s;
        longint       sv;
        longint       p;
        mb  = binv ? ~rb : rb;
        n   = int'(rb) % W;
        res = '0; co = 1'b0; ovf = 1'b0; lat = 1;
        case (op)
            3'b000: res = ra & mb;
            3'b001: res = ($signed(ra) < $signed(rb)) ? W'(1) : W'(0);
            3'b010: res = ra | mb;
            3'b011: res = ra ^ mb;
            3'b100: begin
                s   = longint'(ra) + longint'(mb) + longint'(cin);
                sv  = longint'($signed(ra)) + longint'($signed(mb)) + longint'(cin);
                res = W'(s);
                co  = (s >= (longint'(1) << W));
                ovf = (sv > 32767) || (sv < -32768);
            end
            3'b101: begin
                res = ra << n;
                co  = (n == 0) ? 1'b0 : ra[W-n];
                lat = 1 + n;
            end
            3'b110: begin
                res = ra >> n;
                co  = (n == 0) ? 1'b0 : ra[n-1];
                lat = 1 + n;
            end
            default: begin
                p   = longint'(ra) * longint'(rb);
                res = W'(p);
                co  = ((p >> W) != 0);
                ovf = co;
                lat = W + 1;
            end
        endcase
    endtask

    task automatic runOp(input logic [2:0] op, input logic [W-1:0] ra, input logic [W-1:0] rb,
                         input logic binv, input logic cin, input int holdCycles, input logic junkValid);
        logic [W-1:0] eRes;
        logic [W-1:0] got;
        logic         eCo;
        logic         eOvf;
        int           eLat;
        int           lat;
        logic         seen;
        refModel(op, ra, rb, binv, cin, eRes, eCo, eOvf, eLat);
        expQ.push_back(eRes);
        @(negedge clk);
        check("in_ready_idle", in_ready, 1);
        in_valid = 1'b1; operation = op; a = ra; b = rb; binvert = binv; carry_in = cin;
        @(posedge clk);
        #1;
        if (junkValid) begin
            a = W'($urandom); b = W'($urandom); operation = 3'($urandom);
        end else begin
            in_valid = 1'b0;
        end
        lat = 0;
        seen = 1'b0;
        while (!seen && lat < 100) begin
            @(negedge clk);
            lat++;
            if (out_valid) seen = 1'b1;
            else out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b0;
        got = expQ.pop_front();
        check("latency", lat, eLat);
        check("result", result, got);
        check("carry_out", carry_out, eCo);
        check("overflow", overflow, eOvf);
        check("zero", zero, (got == '0));
        check("busy_done", busy, 1);
        for (int i = 0; i < holdCycles; i++) begin
            @(negedge clk);
            check("hold_valid", out_valid, 1);
            check("hold_result", {carry_out, overflow, zero, result}, {eCo, eOvf, (got == '0), got});
        end
        check("in_ready_in_done", in_ready, 0);
        out_ready = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        out_ready = 1'b0;
        check("valid_dropped", out_valid, 0);
        check("in_ready_after", in_ready, 1);
    endtask

    initial begin
        int badValid;
        repeat (3) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_result", result, 0);
        check("rst_flags", {carry_out, overflow, zero, busy}, 4'b0000);
        reset = 1'b0;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);

        runOp(3'b100, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 0, 1'b0);
        runOp(3'b100, 16'h0005, 16'h0005, 1'b1, 1'b1, 1, 1'b0);
        runOp(3'b001, 16'hFFFF, 16'h0001, 1'b1, 1'b1, 0, 1'b0);
        runOp(3'b001, 16'h7FFF, 16'h8000, 1'b0, 1'b0, 0, 1'b0);
        runOp(3'b000, 16'hF0F0, 16'h0FF0, 1'b1, 1'b0, 0, 1'b0);
        runOp(3'b010, 16'h1200, 16'h0034, 1'b0, 1'b0, 0, 1'b0);
        runOp(3'b011, 16'hAAAA, 16'hAAAA, 1'b0, 1'b0, 0, 1'b0);
        runOp(3'b101, 16'h0001, 16'd15, 1'b1, 1'b0, 0, 1'b0);
        runOp(3'b110, 16'h0003, 16'd1, 1'b0, 1'b0, 0, 1'b0);
        runOp(3'b101, 16'h1234, 16'd0, 1'b0, 1'b0, 0, 1'b0);
        runOp(3'b111, 16'h0100, 16'h0100, 1'b1, 1'b1, 3, 1'b1);

        for (int i = 0; i < 40; i++) begin
            runOp(3'($urandom_range(0, 7)), W'($urandom), W'($urandom), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        // Reset partway through a multiply while extra commands are offered.
        @(negedge clk);
        in_valid = 1'b1; operation = 3'b111; a = 16'h00FF; b = 16'h00FF;
        @(posedge clk);
        #1;
        a = 16'h0001; b = 16'h0001; operation = 3'b100;
        repeat (5) @(negedge clk);
        check("mul_busy_in_ready", in_ready, 0);
        reset = 1'b1;
        #1;
        check("async_rst_busy", busy, 0);
        check("async_rst_result", {out_valid, result}, 0);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        badValid = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) badValid++;
        end
        check("no_valid_after_abort", badValid, 0);
        check("in_ready_after_abort", in_ready, 1);
        runOp(3'b100, 16'd2, 16'd3, 1'b0, 1'b0, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule

// File: doc/alu_nbit_seq.md
ALU_NBIT_SEQ -- requirements
Module: alu_nbit_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, the operand and result width, a power of two and at least 4.
REQ-002 The block SHALL have parameter SHW, default $clog2(WIDTH), the width of the shift-amount field.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 in_valid  in  1  command valid.
REQ-006 in_ready  out  1  block can accept a command.
REQ-007 a, b  in  WIDTH each  operands.
REQ-008 binvert  in  1  invert b before use (ops 000, 010, 011, 100).
REQ-009 carry_in  in  1  adder carry input.
REQ-010 operation  in  3  000 AND, 001 SLT, 010 OR, 011 XOR, 100 ADD, 101 SLL, 110 SRL, 111 MUL.
REQ-011 out_valid  out  1  result valid.
REQ-012 out_ready  in  1  consumer accepts the result.
REQ-013 result  out  WIDTH  registered result.
REQ-014 carry_out, overflow, zero  out  1 each  registered flags.
REQ-015 busy  out  1  high when state is not IDLE.

Function
REQ-016 The FSM SHALL have the states IDLE, EXEC and DONE; in_ready SHALL be 1 only in IDLE.
REQ-017 Accept SHALL occur on in_valid && in_ready, which latches a, b, binvert, carry_in and operation; in_valid outside IDLE SHALL be ignored.
REQ-018 mb SHALL equal ~b if binvert = 1, else b.
REQ-019 Ops 000/010/011 SHALL compute a&mb, a|mb and a^mb, with carry_out = 0 and overflow = 0.
REQ-020 ADD SHALL compute {carry_out,result} = a + mb + carry_in, with overflow = (a[MSB]==mb[MSB]) && (result[MSB]!=a[MSB]).
REQ-021 SLT SHALL always evaluate a + ~b + 1 regardless of binvert and carry_in, with result = {0..., sum[MSB]^ovf} and carry_out = 0 and overflow = 0.
REQ-022 Ops 000–100 SHALL go IDLE->DONE, and out_valid SHALL rise the cycle after accept (latency 1).
REQ-023 SLL/SRL SHALL use shift amount n = b[SHW-1:0], ignore binvert, and shift one bit per EXEC cycle, zero-filling.
REQ-024 For SLL/SRL, carry_out SHALL be the last bit shifted out (0 if n = 0), and overflow SHALL be 0.
REQ-025 For SLL/SRL, latency SHALL be 1+n cycles from accept to out_valid, and n = 0 SHALL go directly to DONE.
REQ-026 MUL SHALL be an unsigned shift-add over WIDTH EXEC cycles with latency WIDTH+1, ignoring binvert and carry_in.
REQ-027 For MUL, result SHALL be the low WIDTH bits of the product, and carry_out = overflow = (high half != 0).
REQ-028 zero SHALL be (result == 0), registered together with result.
REQ-029 In DONE, out_valid = 1 and result and flags SHALL hold stable until out_ready.
REQ-030 On out_valid && out_ready the FSM SHALL go to IDLE, and in_ready SHALL rise the next cycle (no same-cycle accept).
REQ-031 An internal iteration counter SHALL count down to 0 and SHALL never wrap; EXEC->DONE SHALL occur when the counter reaches 0.
REQ-032 out_ready while not in DONE SHALL have no effect.

Reset
REQ-033 On reset, state SHALL go to IDLE asynchronously, and result, carry_out, overflow, zero, out_valid, busy and the counter SHALL go to 0.
REQ-034 in_ready SHALL be 1 while reset is deasserted in IDLE.
REQ-035 Reset mid-EXEC or in DONE SHALL discard the operation, with no out_valid pulse after release.

Verification (WIDTH=16)
REQ-036 ADD a=0x7FFF b=0x0001 cin=0 binv=0 -> cycle after accept: out_valid=1, result=0x8000, overflow=1, carry_out=0, zero=0.
REQ-037 ADD binv=1 cin=1 a=0x0005 b=0x0005 -> result=0x0000, zero=1, carry_out=1, overflow=0.
REQ-038 SLT a=0xFFFF b=0x0001 -> result=0x0001; then a=0x7FFF b=0x8000 -> result=0x0000.
REQ-039 SLL a=0x0001 b=15 -> out_valid 16 cycles after accept, result=0x8000, carry_out=0; SRL a=0x0003 b=1 -> result=0x0001, carry_out=1, latency 2; SLL b=0 -> latency 1, result=a.
REQ-040 MUL a=0x0100 b=0x0100, out_ready held low 3 cycles -> out_valid at accept+17, result=0x0000, carry_out=overflow=zero=1, outputs stable while out_ready is low, in_ready rises the cycle after out_ready.
REQ-041 Reset pulsed 5 cycles into a MUL, in_valid held high during busy -> no out_valid, extra commands ignored, in_ready=1 after release, and a following ADD 2+3 returns 0x0005 at latency 1.
